// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - FIFO-buffered SET/RESET/TOGGLE/HOLD command sequencer driving a JK flip-flop bank.
// Optional JK_CMD_SEQUENCER_SHADOW_EN adds q_model, a shadow of the downstream Q values.
module jk_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             async_reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_rep,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
`ifdef JK_CMD_SEQUENCER_SHADOW_EN
  output logic [WIDTH-1:0] q_model,
`endif
  output logic             done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;

  logic [1:0]       fifo_op_q   [DEPTH];
  logic [WIDTH-1:0] fifo_mask_q [DEPTH];
  logic [CNT_W-1:0] fifo_rep_q  [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  logic fifo_empty, fifo_full, push, pop;

  // The extra pointer bit separates full (wrap bits differ) from empty (pointers equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign pop        = !fifo_empty && ((state_q == IDLE) || (rem_q == '0));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op_q[wr_ptr_q[AW-1:0]]   <= cmd_op;
      fifo_mask_q[wr_ptr_q[AW-1:0]] <= cmd_mask;
      fifo_rep_q[wr_ptr_q[AW-1:0]]  <= cmd_rep;
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = ISSUE;
      ISSUE:   if ((rem_q == '0) && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Active command: reload on pop, otherwise count down the remaining repeats.
  always_comb begin
    op_d   = op_q;
    mask_d = mask_q;
    rem_d  = rem_q;
    if (pop) begin
      op_d   = fifo_op_q[rd_ptr_q[AW-1:0]];
      mask_d = fifo_mask_q[rd_ptr_q[AW-1:0]];
      rem_d  = fifo_rep_q[rd_ptr_q[AW-1:0]];
    end else if ((state_q == ISSUE) && (rem_q != '0)) begin
      rem_d  = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    j_d = '0;
    k_d = '0;
    if (state_d == ISSUE) begin
      case (op_d)
        OP_SET:    j_d = mask_d;
        OP_RESET:  k_d = mask_d;
        OP_TOGGLE: begin
          j_d = mask_d;
          k_d = mask_d;
        end
        OP_HOLD:   ;
        default:   ;
      endcase
    end
    busy = (state_q == ISSUE) || !fifo_empty;
    done = (state_q == ISSUE) && (rem_q == '0) && fifo_empty;
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      op_q   <= OP_HOLD;
      mask_q <= '0;
      rem_q  <= '0;
      j_q    <= '0;
      k_q    <= '0;
    end else begin
      op_q   <= op_d;
      mask_q <= mask_d;
      rem_q  <= rem_d;
      j_q    <= j_d;
      k_q    <= k_d;
    end
  end

  assign j = j_q;
  assign k = k_q;

`ifdef JK_CMD_SEQUENCER_SHADOW_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;

  // Mirrors what the downstream flip-flops will capture from the registered j/k.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j_q[i], k_q[i]})
        2'b10:   shadow_d[i] = 1'b1;
        2'b01:   shadow_d[i] = 1'b0;
        2'b11:   shadow_d[i] = ~shadow_q[i];
        default: shadow_d[i] = shadow_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign q_model = shadow_q;
`endif

endmodule
